// File: rtl/note_hit_judge_if.sv
// ============================================================================
// Module : note_hit_judge_if
// Brief  : Player-side judge bus: game/note inputs and hit/miss/score outputs.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface note_hit_judge_if;
    logic        start_i;
    logic        btn_i;
    logic        note_valid_i;
    logic [9:0]  note_y_i;
    logic        hit_pulse_o;
    logic        perfect_o;
    logic        miss_pulse_o;
    logic        note_clear_o;
    logic [15:0] score_o;
    logic [7:0]  combo_o;

    modport master (
        output start_i, btn_i, note_valid_i, note_y_i,
        input  hit_pulse_o, perfect_o, miss_pulse_o, note_clear_o, score_o, combo_o
    );

    modport slave (
        input  start_i, btn_i, note_valid_i, note_y_i,
        output hit_pulse_o, perfect_o, miss_pulse_o, note_clear_o, score_o, combo_o
    );
endinterface

`default_nettype wire

// File: rtl/note_hit_judge.sv
// ============================================================================
// Module : note_hit_judge
// Brief  : Judges debounced button presses against a falling note at the
//          strike line; emits hit/miss pulses, saturating score and combo.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module note_hit_judge #(
    parameter int STRIKE_Y    = 400,
    parameter int GOOD_WIN    = 24,
    parameter int PERFECT_WIN = 8,
    parameter int DB_CYCLES   = 500000,
    parameter int DB_W        = 20
) (
    input  wire logic        clk,
    input  wire logic        rst,
    note_hit_judge_if.slave  bus
);

    localparam logic signed [10:0] C_STRIKE  = 11'(STRIKE_Y);
    localparam logic signed [10:0] C_GOOD    = 11'(GOOD_WIN);
    localparam logic signed [10:0] C_PERFECT = 11'(PERFECT_WIN);
    localparam logic [DB_W-1:0]    C_DB_LAST = DB_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_INWIN  = 2'd2,
        S_JUDGED = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              sync1_q, sync2_q;
    logic [DB_W-1:0]   db_cnt_q;
    logic              db_level_q, db_prev_q;
    logic [9:0]        note_y_prev_q;
    logic              hit_q, hit_d;
    logic              perfect_q, perfect_d;
    logic              miss_q, miss_d;
    logic              clear_q, clear_d;
    logic [15:0]       score_q, score_d;
    logic [7:0]        combo_q, combo_d;

    logic              w_press;
    logic signed [10:0] w_d;
    logic signed [10:0] w_absd;
    logic              w_inwin, w_perf, w_past, w_below, w_wrap;
    logic [16:0]       w_score_sum;

    // Debounced level only follows the synced button after it has been stable
    // for DB_CYCLES consecutive samples; any return to the old level restarts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            db_cnt_q      <= '0;
            db_level_q    <= 1'b0;
            db_prev_q     <= 1'b0;
            note_y_prev_q <= '0;
        end else begin
            sync1_q       <= bus.btn_i;
            sync2_q       <= sync1_q;
            db_prev_q     <= db_level_q;
            note_y_prev_q <= bus.note_y_i;
            if (sync2_q == db_level_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q == C_DB_LAST) begin
                db_level_q <= sync2_q;
                db_cnt_q   <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + DB_W'(1);
            end
        end
    end

    assign w_press = db_level_q & ~db_prev_q;

    assign w_d     = $signed({1'b0, bus.note_y_i}) - C_STRIKE;
    assign w_absd  = w_d[10] ? -w_d : w_d;
    assign w_inwin = bus.note_valid_i && (w_absd <= C_GOOD);
    assign w_perf  = (w_absd <= C_PERFECT);
    assign w_past  = bus.note_valid_i && (w_d > C_GOOD);
    assign w_below = (w_d < -C_GOOD);
    assign w_wrap  = (bus.note_y_i < note_y_prev_q);
    assign w_score_sum = {1'b0, score_q} + (w_perf ? 17'd2 : 17'd1);

    always_comb begin
        state_d   = state_q;
        hit_d     = 1'b0;
        perfect_d = 1'b0;
        miss_d    = 1'b0;
        clear_d   = 1'b0;
        score_d   = score_q;
        combo_d   = combo_q;

        if (!bus.start_i) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: state_d = S_ARMED;
                S_ARMED: begin
                    if (w_press)      miss_d  = 1'b1;
                    else if (w_inwin) state_d = S_INWIN;
                end
                // A press wins over a simultaneous window exit.
                S_INWIN: begin
                    if (w_press) begin
                        hit_d     = 1'b1;
                        perfect_d = w_perf;
                        clear_d   = 1'b1;
                        state_d   = S_JUDGED;
                        score_d   = w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
                        combo_d   = (combo_q == 8'hFF) ? 8'hFF : combo_q + 8'd1;
                    end else if (w_past || !bus.note_valid_i || w_wrap) begin
                        miss_d  = 1'b1;
                        state_d = S_JUDGED;
                    end
                end
                S_JUDGED: begin
                    if (w_press)                           miss_d  = 1'b1;
                    else if (!bus.note_valid_i || w_below) state_d = S_ARMED;
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (miss_d) combo_d = 8'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            hit_q     <= 1'b0;
            perfect_q <= 1'b0;
            miss_q    <= 1'b0;
            clear_q   <= 1'b0;
            score_q   <= '0;
            combo_q   <= '0;
        end else begin
            state_q   <= state_d;
            hit_q     <= hit_d;
            perfect_q <= perfect_d;
            miss_q    <= miss_d;
            clear_q   <= clear_d;
            score_q   <= score_d;
            combo_q   <= combo_d;
        end
    end

    assign bus.hit_pulse_o  = hit_q;
    assign bus.perfect_o    = perfect_q;
    assign bus.miss_pulse_o = miss_q;
    assign bus.note_clear_o = clear_q;
    assign bus.score_o      = score_q;
    assign bus.combo_o      = combo_q;

endmodule

`default_nettype wire

// File: tb/tb_note_hit_judge.sv
// ============================================================================
// Module : tb_note_hit_judge
// Brief  : Directed self-checking bench for note_hit_judge (DB_CYCLES = 4).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_note_hit_judge;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    int   hit_cnt  = 0;
    int   perf_cnt = 0;
    int   miss_cnt = 0;
    int   clr_cnt  = 0;
    int   last_y   = 0;
    int   miss_y   = -1;

    int   hit0, perf0, miss0;

    note_hit_judge_if u_if ();

    note_hit_judge #(
        .STRIKE_Y    (400),
        .GOOD_WIN    (24),
        .PERFECT_WIN (8),
        .DB_CYCLES   (4),
        .DB_W        (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse bookkeeping on the falling edge; last_y holds the note_y that the
    // DUT judged on the rising edge which produced the pulse being seen.
    always @(negedge clk) begin
        if (u_if.hit_pulse_o)                   hit_cnt++;
        if (u_if.hit_pulse_o && u_if.perfect_o) perf_cnt++;
        if (u_if.note_clear_o)                  clr_cnt++;
        if (u_if.miss_pulse_o) begin
            miss_cnt++;
            miss_y = last_y;
        end
        last_y = int'(u_if.note_y_i);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, observed no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Ramp note_y by one row per cycle; btn rises on press_y (-1 = never) and
    // is held to the end of the ramp, then released and allowed to settle.
    task automatic ramp(input int y0, input int y1, input int press_y);
        for (int y = y0; y <= y1; y++) begin
            u_if.note_y_i = 10'(y);
            if (y == press_y) u_if.btn_i = 1'b1;
            step(1);
        end
        u_if.btn_i = 1'b0;
        step(10);
    endtask

    initial begin
        rst               = 1'b1;
        u_if.start_i      = 1'b0;
        u_if.btn_i        = 1'b0;
        u_if.note_valid_i = 1'b0;
        u_if.note_y_i     = 10'd0;
        step(3);

        chk("reset_hit",     32'(u_if.hit_pulse_o),  0);
        chk("reset_perfect", 32'(u_if.perfect_o),    0);
        chk("reset_miss",    32'(u_if.miss_pulse_o), 0);
        chk("reset_clear",   32'(u_if.note_clear_o), 0);
        chk("reset_score",   32'(u_if.score_o),      0);
        chk("reset_combo",   32'(u_if.combo_o),      0);

        rst               = 1'b0;
        u_if.start_i      = 1'b1;
        u_if.note_valid_i = 1'b1;
        u_if.note_y_i     = 10'd300;
        step(2);

        // Press judged at note_y=403: PERFECT.
        ramp(300, 420, 397);
        chk("hit1_count",   32'(hit_cnt),  1);
        chk("hit1_perfect", 32'(perf_cnt), 1);
        chk("hit1_clear",   32'(clr_cnt),  1);
        chk("hit1_nomiss",  32'(miss_cnt), 0);
        chk("hit1_score",   32'(u_if.score_o), 2);
        chk("hit1_combo",   32'(u_if.combo_o), 1);

        // Press judged at note_y=412: GOOD.
        ramp(300, 420, 406);
        chk("hit2_count",   32'(hit_cnt),  2);
        chk("hit2_perfect", 32'(perf_cnt), 1);
        chk("hit2_nomiss",  32'(miss_cnt), 0);
        chk("hit2_score",   32'(u_if.score_o), 3);
        chk("hit2_combo",   32'(u_if.combo_o), 2);

        // Press judged at note_y=400: PERFECT.
        ramp(300, 420, 394);
        chk("hit3_score",   32'(u_if.score_o), 5);
        chk("hit3_combo",   32'(u_if.combo_o), 3);

        // Stray press far above the strike line.
        u_if.note_y_i = 10'd200;
        step(2);
        u_if.btn_i = 1'b1;
        step(12);
        u_if.btn_i = 1'b0;
        step(10);
        chk("stray_miss",  32'(miss_cnt), 1);
        chk("stray_nohit", 32'(hit_cnt),  3);
        chk("stray_combo", 32'(u_if.combo_o), 0);
        chk("stray_score", 32'(u_if.score_o), 5);

        // Two-cycle glitch must not debounce into a press.
        u_if.btn_i = 1'b1;
        step(2);
        u_if.btn_i = 1'b0;
        step(12);
        chk("glitch_nomiss", 32'(miss_cnt), 1);
        chk("glitch_nohit",  32'(hit_cnt),  3);

        ramp(300, 420, 394);
        chk("hit4_score", 32'(u_if.score_o), 7);
        chk("hit4_combo", 32'(u_if.combo_o), 1);

        // Note passes through the window untouched: one miss at note_y=425.
        ramp(370, 430, -1);
        chk("pass_miss_count", 32'(miss_cnt), 2);
        chk("pass_miss_y",     32'(miss_y),   425);
        chk("pass_nohit",      32'(hit_cnt),  4);
        chk("pass_combo",      32'(u_if.combo_o), 0);
        chk("pass_score",      32'(u_if.score_o), 7);

        // Preload near saturation, holding across one clock edge.
        @(negedge clk);
        force dut.score_q = 16'hFFFE;
        force dut.combo_q = 8'hFF;
        @(negedge clk);
        release dut.score_q;
        release dut.combo_q;
        step(1);
        chk("preload_score", 32'(u_if.score_o), 32'hFFFE);
        chk("preload_combo", 32'(u_if.combo_o), 32'hFF);

        ramp(300, 420, 394);
        chk("sat1_score", 32'(u_if.score_o), 32'hFFFF);
        chk("sat1_combo", 32'(u_if.combo_o), 32'hFF);
        ramp(300, 420, 394);
        chk("sat2_score",   32'(u_if.score_o), 32'hFFFF);
        chk("sat2_combo",   32'(u_if.combo_o), 32'hFF);
        chk("sat2_perfect", 32'(perf_cnt), 5);
        chk("sat2_nomiss",  32'(miss_cnt), 2);

        // Asynchronous reset while the note sits in the window with btn high.
        for (int y = 300; y <= 380; y++) begin
            u_if.note_y_i = 10'(y);
            step(1);
        end
        u_if.btn_i = 1'b1;
        step(2);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_score",   32'(u_if.score_o),      0);
        chk("arst_combo",   32'(u_if.combo_o),      0);
        chk("arst_hit",     32'(u_if.hit_pulse_o),  0);
        chk("arst_miss",    32'(u_if.miss_pulse_o), 0);
        chk("arst_clear",   32'(u_if.note_clear_o), 0);
        chk("arst_perfect", 32'(u_if.perfect_o),    0);
        step(3);
        chk("rst_hold_score", 32'(u_if.score_o),     0);
        chk("rst_hold_hit",   32'(u_if.hit_pulse_o), 0);

        hit0  = hit_cnt;
        perf0 = perf_cnt;
        miss0 = miss_cnt;
        u_if.start_i = 1'b0;
        rst          = 1'b0;
        step(20);
        chk("idle_nohit",  32'(hit_cnt),  32'(hit0));
        chk("idle_nomiss", 32'(miss_cnt), 32'(miss0));
        chk("idle_noperf", 32'(perf_cnt), 32'(perf0));
        chk("idle_score",  32'(u_if.score_o), 0);
        chk("idle_combo",  32'(u_if.combo_o), 0);
        u_if.btn_i = 1'b0;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
